// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring radix-2 divider (quotient/remainder), optional early-out via DIV_ITER_EARLY_OUT_EN
module div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_signed,
    input  logic            in_word,
    input  logic            in_rem,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    // Word operations use the low 32 bits, so XLEN must exceed 32.
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q;
    logic            sgn_q, word_q, rem_sel_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            neg_quo_q, neg_rem_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
    logic            a_neg, b_neg, b_zero;
    logic [XLEN:0]   rem_shift, diff;
    logic [XLEN-1:0] quo_fix, rem_fix, sel, result;

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic sx);
        return sx ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Operand conditioning for PREP, the restoring step for ITER and sign fix-up for FIX
    always_comb begin
        a_ext     = word_q ? word_ext(a_q, sgn_q) : a_q;
        b_ext     = word_q ? word_ext(b_q, sgn_q) : b_q;
        a_neg     = sgn_q & a_ext[XLEN-1];
        b_neg     = sgn_q & b_ext[XLEN-1];
        a_abs     = a_neg ? -a_ext : a_ext;
        b_abs     = b_neg ? -b_ext : b_ext;
        b_zero    = (b_ext == '0);
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        quo_fix   = neg_quo_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
        sel       = rem_sel_q ? rem_fix : quo_fix;
        result    = word_q ? word_ext(sel, 1'b1) : sel;
    end

`ifdef DIV_ITER_EARLY_OUT_EN
    logic ovf;
    // Signed most-negative / -1 at the operation width
    always_comb begin
        ovf = sgn_q && (b_ext == '1) && (a_ext == (word_q ? MIN_W : MIN_X));
    end
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush wins over accept and completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = PREP;
`ifdef DIV_ITER_EARLY_OUT_EN
            PREP: state_d = (b_zero || ovf) ? FIX : ITER;
`else
            PREP: state_d = ITER;
`endif
            ITER: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: latch request, condition operands, iterate, register result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            word_q    <= 1'b0;
            rem_sel_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            out_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        sgn_q     <= in_signed;
                        word_q    <= in_word;
                        rem_sel_q <= in_rem;
                    end
                end
                PREP: begin
                    quo_q     <= a_abs;
                    rem_q     <= '0;
                    dvs_q     <= b_abs;
                    // Divide-by-zero keeps an all-ones quotient regardless of signs
                    neg_quo_q <= (a_neg ^ b_neg) & ~b_zero;
                    neg_rem_q <= a_neg;
                    cnt_q     <= CW'(XLEN-1);
`ifdef DIV_ITER_EARLY_OUT_EN
                    // Preload what the iterations would have produced
                    if (b_zero) begin
                        quo_q <= '1;
                        rem_q <= a_abs;
                    end else if (ovf) begin
                        quo_q <= a_abs;
                        rem_q <= '0;
                    end
`endif
                end
                ITER: begin
                    if (!diff[XLEN]) begin
                        rem_q <= diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    if (!flush) out_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule
